// File: rtl/simd_alu_pipe_pkg.sv
// Shared types for the pipelined SIMD ALU: opcode encodings and per-lane flag bundle.
package simd_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_ROL  = 5'd8,
    OP_ROR  = 5'd9,
    OP_SLT  = 5'd10,
    OP_SLTU = 5'd11,
    OP_MIN  = 5'd12,
    OP_MAX  = 5'd13,
    OP_RSUM = 5'd14
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic carry;
  } lane_flags_t;

  localparam int unsigned NUM_OPS = 15;

endpackage

// File: rtl/simd_alu_pipe_if.sv
// Handshake and data bundle between the issue stage, the SIMD ALU and writeback.
interface simd_alu_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int OP_WIDTH   = 5,
  parameter int TAG_WIDTH  = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [OP_WIDTH-1:0]         in_op;
  logic [LANES*DATA_WIDTH-1:0] in_a;
  logic [LANES*DATA_WIDTH-1:0] in_b;
  logic [LANES-1:0]            in_mask;
  logic                        in_sat;
  logic [TAG_WIDTH-1:0]        in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_result;
  logic [LANES-1:0]            out_zero;
  logic [LANES-1:0]            out_negative;
  logic [LANES-1:0]            out_overflow;
  logic [LANES-1:0]            out_carry;
  logic                        out_illegal;
  logic [TAG_WIDTH-1:0]        out_tag;
  logic [LANES-1:0]            sticky_ovf;
  logic                        clr_sticky;

  modport master (
    output in_valid, in_op, in_a, in_b, in_mask, in_sat, in_tag, out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_zero, out_negative, out_overflow,
           out_carry, out_illegal, out_tag, sticky_ovf
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_mask, in_sat, in_tag, out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_zero, out_negative, out_overflow,
           out_carry, out_illegal, out_tag, sticky_ovf
  );
endinterface

// File: rtl/simd_alu_pipe_lane.sv
// Combinational single-lane compute unit; masked-off lanes pass a through with flags cleared.
module simd_alu_lane
  import simd_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  alu_op_e               i_op,
  input  logic                  i_sat,
  input  logic                  i_active,
  output logic [DATA_WIDTH-1:0] o_result,
  output lane_flags_t           o_flags
);
  localparam int unsigned MSB = DATA_WIDTH - 1;
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW:0] DW_L = (SHW + 1)'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [SHW-1:0]        w_sh;
  logic [SHW:0]          w_inv_sh;
  logic                  w_add_ovf;
  logic                  w_sub_ovf;
  logic [DATA_WIDTH-1:0] w_sat_val;
  logic [DATA_WIDTH-1:0] w_raw;
  logic                  w_ovf;
  logic                  w_carry;

  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff    = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh      = i_b[SHW-1:0];
  // Shift by the full width yields 0, so a zero rotate amount reduces to i_a.
  assign w_inv_sh  = DW_L - {1'b0, w_sh};
  assign w_add_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
  assign w_sub_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
  assign w_sat_val = i_a[MSB] ? MAX_NEG : MAX_POS;

  always_comb begin
    w_raw   = '0;
    w_ovf   = 1'b0;
    w_carry = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_ovf   = w_add_ovf;
        w_carry = w_sum[DATA_WIDTH];
        w_raw   = (i_sat && w_add_ovf) ? w_sat_val : w_sum[MSB:0];
      end
      OP_SUB: begin
        w_ovf   = w_sub_ovf;
        w_carry = w_diff[DATA_WIDTH];
        w_raw   = (i_sat && w_sub_ovf) ? w_sat_val : w_diff[MSB:0];
      end
      OP_AND:  w_raw = i_a & i_b;
      OP_OR:   w_raw = i_a | i_b;
      OP_XOR:  w_raw = i_a ^ i_b;
      OP_SLL:  w_raw = i_a << w_sh;
      OP_SRL:  w_raw = i_a >> w_sh;
      OP_SRA:  w_raw = $signed(i_a) >>> w_sh;
      OP_ROL:  w_raw = (i_a << w_sh) | (i_a >> w_inv_sh);
      OP_ROR:  w_raw = (i_a >> w_sh) | (i_a << w_inv_sh);
      OP_SLT:  w_raw = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: w_raw = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_MIN:  w_raw = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
      OP_MAX:  w_raw = ($signed(i_a) < $signed(i_b)) ? i_b : i_a;
      default: ;
    endcase
  end

  always_comb begin
    o_result = i_a;
    o_flags  = '0;
    if (i_active) begin
      o_result         = w_raw;
      o_flags.zero     = (w_raw == '0);
      o_flags.negative = w_raw[MSB];
      o_flags.overflow = w_ovf;
      o_flags.carry    = w_carry;
    end
  end
endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD ALU: S1 captures operands, S2 holds results/flags that drive the outputs.
module simd_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int OP_WIDTH   = 5,
  parameter int TAG_WIDTH  = 4
) (
  input logic            clk,
  input logic            rst_n,
  simd_alu_pipe_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH;

  logic                  r_s1_valid;
  logic [OP_WIDTH-1:0]   r_s1_op;
  logic [LANES*DW-1:0]   r_s1_a;
  logic [LANES*DW-1:0]   r_s1_b;
  logic [LANES-1:0]      r_s1_mask;
  logic                  r_s1_sat;
  logic [TAG_WIDTH-1:0]  r_s1_tag;

  logic                  r_s2_valid;
  logic [LANES*DW-1:0]   r_s2_result;
  logic [LANES-1:0]      r_s2_zero;
  logic [LANES-1:0]      r_s2_neg;
  logic [LANES-1:0]      r_s2_ovf;
  logic [LANES-1:0]      r_s2_carry;
  logic                  r_s2_illegal;
  logic [TAG_WIDTH-1:0]  r_s2_tag;
  logic [LANES-1:0]      r_sticky;

  logic                  w_adv1;
  logic                  w_adv2;
  logic                  w_fire;
  alu_op_e               w_op;
  logic                  w_illegal;
  logic [DW-1:0]         w_lane_res [LANES];
  lane_flags_t           w_lane_flags [LANES];
  logic [DW-1:0]         w_rsum;
  logic [LANES*DW-1:0]   w_res;
  logic [LANES-1:0]      w_zero;
  logic [LANES-1:0]      w_neg;
  logic [LANES-1:0]      w_ovf;
  logic [LANES-1:0]      w_carry;

  assign w_adv2       = !r_s2_valid || bus.out_ready;
  assign w_adv1       = !r_s1_valid || w_adv2;
  assign w_fire       = r_s2_valid && bus.out_ready;
  assign bus.in_ready = rst_n && w_adv1;

  assign w_op      = alu_op_e'(r_s1_op[4:0]);
  assign w_illegal = (r_s1_op > OP_WIDTH'(NUM_OPS - 1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_alu_lane #(.DATA_WIDTH(DW)) u_lane (
      .i_a      (r_s1_a[g*DW +: DW]),
      .i_b      (r_s1_b[g*DW +: DW]),
      .i_op     (w_op),
      .i_sat    (r_s1_sat),
      .i_active (r_s1_mask[g]),
      .o_result (w_lane_res[g]),
      .o_flags  (w_lane_flags[g])
    );
  end

  always_comb begin
    w_rsum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_s1_mask[i]) w_rsum = w_rsum + r_s1_a[i*DW +: DW];
    end
  end

  // Illegal opcodes force every lane to zero, including masked-off ones.
  always_comb begin
    w_res   = '0;
    w_zero  = '0;
    w_neg   = '0;
    w_ovf   = '0;
    w_carry = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!w_illegal) begin
        if (w_op == OP_RSUM) begin
          if (i == 0) begin
            w_res[DW-1:0] = w_rsum;
            w_zero[0]     = (w_rsum == '0);
            w_neg[0]      = w_rsum[DW-1];
          end
        end else begin
          w_res[i*DW +: DW] = w_lane_res[i];
          w_zero[i]         = w_lane_flags[i].zero;
          w_neg[i]          = w_lane_flags[i].negative;
          w_ovf[i]          = w_lane_flags[i].overflow;
          w_carry[i]        = w_lane_flags[i].carry;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_op      <= '0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_mask    <= '0;
      r_s1_sat     <= 1'b0;
      r_s1_tag     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_zero    <= '0;
      r_s2_neg     <= '0;
      r_s2_ovf     <= '0;
      r_s2_carry   <= '0;
      r_s2_illegal <= 1'b0;
      r_s2_tag     <= '0;
      r_sticky     <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_op   <= bus.in_op;
          r_s1_a    <= bus.in_a;
          r_s1_b    <= bus.in_b;
          r_s1_mask <= bus.in_mask;
          r_s1_sat  <= bus.in_sat;
          r_s1_tag  <= bus.in_tag;
        end
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result  <= w_res;
          r_s2_zero    <= w_zero;
          r_s2_neg     <= w_neg;
          r_s2_ovf     <= w_ovf;
          r_s2_carry   <= w_carry;
          r_s2_illegal <= w_illegal;
          r_s2_tag     <= r_s1_tag;
        end
      end
      // A set on the same edge as a clear survives the clear.
      r_sticky <= (bus.clr_sticky ? '0 : r_sticky) | (w_fire ? r_s2_ovf : '0);
    end
  end

  assign bus.out_valid    = r_s2_valid;
  assign bus.out_result   = r_s2_result;
  assign bus.out_zero     = r_s2_zero;
  assign bus.out_negative = r_s2_neg;
  assign bus.out_overflow = r_s2_ovf;
  assign bus.out_carry    = r_s2_carry;
  assign bus.out_illegal  = r_s2_illegal;
  assign bus.out_tag      = r_s2_tag;
  assign bus.sticky_ovf   = r_sticky;
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Self-checking bench for simd_alu_pipe: directed scenarios plus randomized traffic vs a behavioural model.
module tb_simd_alu_pipe;
  import simd_alu_pkg::*;

  localparam int DW = 32;
  localparam int L = 4;
  localparam int OPW = 5;
  localparam int TW = 4;

  typedef struct packed {
    logic [L*DW-1:0] res;
    logic [L-1:0]    z;
    logic [L-1:0]    n;
    logic [L-1:0]    v;
    logic [L-1:0]    c;
    logic            ill;
    logic [TW-1:0]   tag;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_alu_pipe_if #(.DATA_WIDTH(DW), .LANES(L), .OP_WIDTH(OPW), .TAG_WIDTH(TW)) bus ();

  simd_alu_pipe #(.DATA_WIDTH(DW), .LANES(L), .OP_WIDTH(OPW), .TAG_WIDTH(TW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rec_t got_q[$];
  rec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      rec_t r;
      r.res = bus.out_result;
      r.z   = bus.out_zero;
      r.n   = bus.out_negative;
      r.v   = bus.out_overflow;
      r.c   = bus.out_carry;
      r.ill = bus.out_illegal;
      r.tag = bus.out_tag;
      got_q.push_back(r);
    end
  end

  // Reference model: per-lane integer arithmetic on 64-bit values.
  function automatic rec_t model(input logic [4:0] op, input logic [L*DW-1:0] a,
                                 input logic [L*DW-1:0] b, input logic [L-1:0] m,
                                 input logic s, input logic [TW-1:0] tag);
    rec_t        e;
    logic [31:0] ai, bi, r, sum;
    logic [63:0] ua, ub, full;
    longint      sa, sb, ss;
    int          sh;
    logic        v, c;
    e = '0;
    e.tag = tag;
    if (op > 5'd14) begin
      e.ill = 1'b1;
      return e;
    end
    if (op == 5'd14) begin
      sum = 32'd0;
      for (int i = 0; i < L; i++) if (m[i]) sum = sum + a[i*DW +: DW];
      e.res[31:0] = sum;
      e.z[0] = (sum == 32'd0);
      e.n[0] = sum[31];
      return e;
    end
    for (int i = 0; i < L; i++) begin
      ai = a[i*DW +: DW];
      bi = b[i*DW +: DW];
      if (!m[i]) begin
        e.res[i*DW +: DW] = ai;
        continue;
      end
      ua = {32'd0, ai};
      ub = {32'd0, bi};
      sa = longint'($signed(ai));
      sb = longint'($signed(bi));
      sh = int'(bi[4:0]);
      v = 1'b0;
      c = 1'b0;
      r = 32'd0;
      case (op)
        5'd0: begin
          full = ua + ub; r = full[31:0]; c = full[32]; ss = sa + sb;
          v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
          if (s && v) r = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        5'd1: begin
          full = ua - ub; r = full[31:0]; c = (ua < ub); ss = sa - sb;
          v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
          if (s && v) r = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        5'd2: r = ai & bi;
        5'd3: r = ai | bi;
        5'd4: r = ai ^ bi;
        5'd5: begin full = ua << sh; r = full[31:0]; end
        5'd6: r = ai >> sh;
        5'd7: begin ss = sa >>> sh; r = ss[31:0]; end
        5'd8: begin full = (ua << sh) | (ua >> (32 - sh)); r = full[31:0]; end
        5'd9: begin full = (ua >> sh) | (ua << (32 - sh)); r = full[31:0]; end
        5'd10: r = (sa < sb) ? 32'd1 : 32'd0;
        5'd11: r = (ua < ub) ? 32'd1 : 32'd0;
        5'd12: r = (sa < sb) ? ai : bi;
        default: r = (sa > sb) ? ai : bi;
      endcase
      e.res[i*DW +: DW] = r;
      e.z[i] = (r == 32'd0);
      e.n[i] = r[31];
      e.v[i] = v;
      e.c[i] = c;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom % 8)
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_in(input logic [4:0] op, input logic [L*DW-1:0] a, input logic [L*DW-1:0] b,
                        input logic [L-1:0] m, input logic s, input logic [TW-1:0] tag);
    bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_mask = m; bus.in_sat = s; bus.in_tag = tag;
  endtask

  // Drives one operation and returns 1 time unit after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [L*DW-1:0] a, input logic [L*DW-1:0] b,
                       input logic [L-1:0] m, input logic s, input logic [TW-1:0] tag);
    bit ok = 0;
    set_in(op, a, b, m, s, tag);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL issue_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    exp_q.push_back(model(op, a, b, m, s, tag));
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL out_timeout: out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic pulse_clr();
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1;
    bus.clr_sticky = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", bus.in_ready);
    else n_pass++;
    n_total++;
    if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow,
         bus.out_carry, bus.out_illegal, bus.out_tag, bus.sticky_ovf} !== '0)
      $display("FAIL reset_outputs: valid=%b res=%h tag=%h ill=%b sticky=%b required all 0",
               bus.out_valid, bus.out_result, bus.out_tag, bus.out_illegal, bus.sticky_ovf);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b required 1", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [L*DW-1:0] a, b, er;
    for (int i = 0; i < L; i++) begin
      a[i*DW +: DW] = 32'(10 + i);
      b[i*DW +: DW] = 32'(5 + i);
      er[i*DW +: DW] = 32'(15 + 2 * i);
    end
    issue(5'd0, a, b, 4'hF, 1'b0, 4'h5);
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_latency_t1: out_valid=%b required 0", bus.out_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL add_latency_t2: out_valid=%b required 1", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.out_result !== er) $display("FAIL add_result: got %h required %h", bus.out_result, er);
    else n_pass++;
    n_total++;
    if ({bus.out_zero, bus.out_negative, bus.out_overflow, bus.out_carry, bus.out_tag} !== {16'h0, 4'h5})
      $display("FAIL add_flags_tag: got z%b n%b v%b c%b tag %h required 0000 x4 tag 5", bus.out_zero,
               bus.out_negative, bus.out_overflow, bus.out_carry, bus.out_tag);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    logic [L*DW-1:0] a, b;
    bit ok;
    a = {32'hAA, 32'hAA, 32'hAA, 32'd20};
    b = {$urandom, $urandom, $urandom, 32'd30};
    issue(5'd1, a, b, 4'b0001, 1'b0, 4'h6);
    wait_out(ok);
    if (ok) begin
      n_total++;
      if (bus.out_result !== {32'hAA, 32'hAA, 32'hAA, 32'hFFFF_FFF6})
        $display("FAIL sub_result: got %h required %h", bus.out_result, {32'hAA, 32'hAA, 32'hAA, 32'hFFFF_FFF6});
      else n_pass++;
      n_total++;
      if ({bus.out_zero, bus.out_negative, bus.out_overflow, bus.out_carry} !== {4'b0000, 4'b0001, 4'b0000, 4'b0001})
        $display("FAIL sub_flags: got z%b n%b v%b c%b required z0000 n0001 v0000 c0001", bus.out_zero,
                 bus.out_negative, bus.out_overflow, bus.out_carry);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [L*DW-1:0] a, b;
    bit ok;
    a = {96'd0, 32'h7FFF_FFFF};
    b = {96'd0, 32'd1};
    pulse_clr();
    issue(5'd0, a, b, 4'b0001, 1'b1, 4'h7);
    wait_out(ok);
    if (ok) begin
      n_total++;
      if ({bus.out_result[31:0], bus.out_overflow} !== {32'h7FFF_FFFF, 4'b0001})
        $display("FAIL sat_on: got %h v%b required 7fffffff v0001", bus.out_result[31:0], bus.out_overflow);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_total++;
    if (bus.sticky_ovf !== 4'b0001) $display("FAIL sticky_set: got %b required 0001", bus.sticky_ovf);
    else n_pass++;
    pulse_clr();
    n_total++;
    if (bus.sticky_ovf !== 4'b0000) $display("FAIL sticky_clear: got %b required 0000", bus.sticky_ovf);
    else n_pass++;
    issue(5'd0, a, b, 4'b0001, 1'b0, 4'h8);
    wait_out(ok);
    if (ok) begin
      n_total++;
      if ({bus.out_result[31:0], bus.out_overflow, bus.out_negative} !== {32'h8000_0000, 4'b0001, 4'b0001})
        $display("FAIL sat_off: got %h v%b n%b required 80000000 v0001 n0001", bus.out_result[31:0],
                 bus.out_overflow, bus.out_negative);
      else n_pass++;
    end
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1;
    bus.clr_sticky = 1'b0;
    n_total++;
    if (bus.sticky_ovf !== 4'b0001) $display("FAIL sticky_set_wins: got %b required 0001", bus.sticky_ovf);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [L*DW-1:0] a, b;
    bit ok;
    got_q.delete();
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      set_in(5'd0, a, b, 4'hF, 1'b0, 4'(t));
      bus.in_valid = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.in_ready !== (t < 3)) $display("FAIL bp_in_ready_%0d: got %b required %b", t, bus.in_ready, t < 3);
      else n_pass++;
      exp_q.push_back(model(5'd0, a, b, 4'hF, 1'b0, 4'(t)));
      if (t < 3) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_total++;
      if ({bus.in_ready, bus.out_valid, bus.out_tag, bus.out_result} !== {1'b0, 1'b1, 4'h1, exp_q[0].res})
        $display("FAIL bp_hold_%0d: rdy=%b vld=%b tag=%h res=%h required 0 1 1 %h", k, bus.in_ready,
                 bus.out_valid, bus.out_tag, bus.out_result, exp_q[0].res);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b required 1", bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (got_q.size() >= 3) begin ok = 1; break; end
    end
    n_total++;
    if (got_q.size() != 3) $display("FAIL bp_drain_count: got %0d required 3", got_q.size());
    else n_pass++;
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) $display("FAIL bp_drain_%0d: got %h required %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rsum();
    logic [L*DW-1:0] a, b;
    bit ok;
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    b = {$urandom, $urandom, $urandom, $urandom};
    issue(5'd14, a, b, 4'b1011, 1'b0, 4'h9);
    wait_out(ok);
    if (ok) begin
      n_total++;
      if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow, bus.out_carry} !== {96'd0, 32'd7, 16'h0})
        $display("FAIL rsum: got res %h z%b n%b v%b c%b required res 7 flags 0", bus.out_result,
                 bus.out_zero, bus.out_negative, bus.out_overflow, bus.out_carry);
      else n_pass++;
    end
    @(posedge clk); #1;
    issue(5'd14, a, b, 4'b0000, 1'b0, 4'hA);
    wait_out(ok);
    if (ok) begin
      n_total++;
      if ({bus.out_result, bus.out_zero} !== {128'd0, 4'b0001})
        $display("FAIL rsum_empty: got res %h z%b required 0 z0001", bus.out_result, bus.out_zero);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    bit ok;
    issue(5'd31, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          4'hF, 1'b1, 4'hB);
    wait_out(ok);
    if (ok) begin
      n_total++;
      if ({bus.out_illegal, bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow, bus.out_carry}
          !== {1'b1, 128'd0, 16'h0})
        $display("FAIL illegal: got ill=%b res=%h flags %b%b%b%b required ill=1 all 0", bus.out_illegal,
                 bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow, bus.out_carry);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight();
    got_q.delete();
    bus.out_ready = 1'b0;
    for (int t = 14; t <= 15; t++) begin
      set_in(5'd0, {4{rand_word()}}, {4{rand_word()}}, 4'hF, 1'b0, 4'(t));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.out_valid, bus.out_tag} !== {1'b1, 4'hE})
      $display("FAIL inflight_pre: vld=%b tag=%h required 1 e", bus.out_valid, bus.out_tag);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00)
      $display("FAIL inflight_reset: vld=%b rdy=%b required 0 0", bus.out_valid, bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_total++;
    if (got_q.size() != 0) $display("FAIL inflight_discard: got %0d outputs required 0", got_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_random();
    logic [4:0]      op;
    logic [L*DW-1:0] a, b;
    logic [L-1:0]    m, sticky;
    logic            s;
    logic [TW-1:0]   tag;
    bit              pending = 0;
    bit              ok;
    pulse_clr();
    got_q.delete();
    exp_q.delete();
    for (int it = 0; it < 400; it++) begin
      if (!pending && ($urandom % 4 != 0)) begin
        op = 5'($urandom_range(0, 16));
        if (op >= 5'd15) op = 5'($urandom_range(15, 31));
        for (int i = 0; i < L; i++) begin
          a[i*DW +: DW] = rand_word();
          b[i*DW +: DW] = rand_word();
        end
        m = 4'($urandom);
        s = 1'($urandom);
        tag = 4'(it);
        set_in(op, a, b, m, s, tag);
        pending = 1;
      end
      bus.in_valid = pending;
      bus.out_ready = ($urandom % 4 != 0);
      @(negedge clk);
      if (pending && bus.in_ready) begin
        exp_q.push_back(model(op, a, b, m, s, tag));
        pending = 0;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size()) begin ok = 1; break; end
    end
    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size());
    else n_pass++;
    sticky = '0;
    if (ok) begin
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        sticky |= exp_q[i].v;
        n_total++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rand_txn_%0d: got %h required %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    n_total++;
    if (bus.sticky_ovf !== sticky) $display("FAIL rand_sticky: got %b required %b", bus.sticky_ovf, sticky);
    else n_pass++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr_sticky = 1'b0;
    set_in(5'd0, '0, '0, '0, 1'b0, '0);
    test_reset();
    test_add();
    test_sub();
    test_saturation();
    test_backpressure();
    test_rsum();
    test_illegal();
    test_reset_inflight();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/simd_alu_pipe.md
# simd_alu_pipe

Parametrised, pipelined successor to the SIMD ALU: `LANES` identical integer lanes of `DATA_WIDTH` bits behind a valid/ready handshake, with per-lane masking, optional signed saturation, a horizontal-sum reduction and sticky per-lane overflow status. It sits between the issue stage and writeback in the RISC-V ALU processor. It replaces the single-`en` SIMD ALU wherever backpressure or a variable lane count is needed.

## Interface
- `DATA_WIDTH`, 32: lane width in bits; must be a power of two, minimum 8.
- `LANES`, 4: number of SIMD lanes; minimum 1.
- `OP_WIDTH`, 5: opcode width.
- `TAG_WIDTH`, 4: width of the opaque tag carried with each operation.

- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_op`  in  OP_WIDTH: opcode, shared by all lanes.
- `in_a`, `in_b`  in  LANES*DATA_WIDTH: operands; lane i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_mask`  in  LANES: 1 marks the lane as active.
- `in_sat`  in  1: enables signed saturation for ADD and SUB.
- `in_tag`  in  TAG_WIDTH: carried unchanged to `out_tag`.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_result`  out  LANES*DATA_WIDTH: result, packed like the operands.
- `out_zero`, `out_negative`, `out_overflow`, `out_carry`  out  LANES: per-lane flags.
- `out_illegal`  out  1: opcode not in the supported set.
- `out_tag`  out  TAG_WIDTH: tag of the current output.
- `sticky_ovf`  out  LANES: per-lane accumulated overflow.
- `clr_sticky`  in  1: clears `sticky_ovf`.

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, ROL=8, ROR=9, SLT=10, SLTU=11, MIN=12, MAX=13, RSUM=14. All other codes are illegal: results and flags are 0 and `out_illegal`=1.
- Shift and rotate amount is `b[$clog2(DATA_WIDTH)-1:0]`. Upper bits of `b` are ignored.
- SLT and SLTU return 1 or 0. MIN and MAX are signed.
- ADD: `carry` is the unsigned carry-out. SUB: `carry` is the borrow (a<b unsigned). `overflow` is the signed overflow for ADD and SUB only; all other ops give 0.
- Saturation (`in_sat`=1, ADD or SUB only): on signed overflow the result clamps to the most positive value (0x7FFF_FFFF at 32 bits) or the most negative value (0x8000_0000). `overflow` is still reported as 1.
- `zero` and `negative` are taken from the final, post-saturation lane result.
- Masked-off lane: the result is `a` passed through unchanged and all four flags are 0.
- RSUM: lane 0 result is the modulo-2^DATA_WIDTH sum of `a` over the active lanes. Lanes 1..LANES-1 output 0 with flags 0. In lane 0, `overflow` and `carry` are 0 and `zero`/`negative` follow the sum. With an all-zero mask, lane 0 outputs 0 and `zero`=1.
- Sticky status: on each output handshake, `sticky_ovf |= out_overflow`. `clr_sticky` clears the register. If a clear and a set occur in the same cycle, the set wins.

## Timing
- Two register stages. S1 captures the inputs. S2 holds the computed results and flags; the S2 registers drive the outputs directly.
- Latency: an operation accepted in cycle t is presented with `out_valid`=1 in cycle t+2 when there is no stall. Throughput is one operation per cycle.
- Stage advance: `adv2 = !out_valid || out_ready`; `adv1 = !s1_valid || adv2`; `in_ready = adv1`. `in_ready` is combinational and never depends on `in_valid`.
- While `out_valid && !out_ready`, every output is held stable. No operation is dropped or duplicated, and results leave in acceptance order.
- Reset: all valid bits and all outputs go to 0, including `sticky_ovf`, `out_tag` and `out_illegal`. `in_ready` is 0 while `rst_n`=0 and 1 in the first cycle after release. Operations in flight at reset are discarded.

## Structure
- Package `simd_alu_pkg` holds the `alu_op_e` enum (the encodings above) and the lane-flag struct (zero, negative, overflow, carry).
- Sub-module `simd_alu_lane` is a purely combinational single-lane compute unit, instantiated LANES times.
- The top level owns the handshake, the pipeline registers, the RSUM adder tree and the sticky register. The RSUM tree sits between S1 and S2.

## Test plan
- ADD: lane i has a=10+i, b=5+i, mask=1111. Required: out_valid 2 cycles after acceptance, lane i result=15+2i, all flags 0.
- SUB: a=20, b=30, mask=0001, other lanes a=0xAA. Required: lane0 result=0xFFFF_FFF6, carry=1, negative=1, overflow=0. Lanes 1..3 result=0xAA with flags 0.
- ADD 0x7FFF_FFFF + 1: with sat=1, result=0x7FFF_FFFF and overflow=1. With sat=0, result=0x8000_0000 and overflow=1. `sticky_ovf[0]` is set after the first handshake. `clr_sticky` asserted in the same cycle as a new overflow handshake leaves the bit set.
- Backpressure: hold out_ready=0 and issue tags 1,2,3 back-to-back. Required: in_ready drops after two acceptances, outputs stay stable, and after release the tags drain 1,2,3 with none lost.
- RSUM: a={1,2,3,4} (lane 0..3), mask=1011. Required: lane0 result=7, lanes 1..3 result=0.
- Illegal opcode 31 gives out_illegal=1 and all results 0. Asserting rst_n=0 with two operations in flight gives out_valid=0 on the next edge, and none of those operations is ever output.
